// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding.
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int CNT_W = 13;
    localparam int IDX_W = $clog2(DATA_BITS);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status pulses out.
interface uart_rx_if;
    import uart_pkg::*;
    logic rx;
    logic [DATA_BITS-1:0] rx_data;
    logic rx_valid;
    logic frame_err;
    logic rx_busy;
    modport master (output rx, input rx_data, rx_valid, frame_err, rx_busy);
    modport slave (input rx, output rx_data, rx_valid, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: bit-period counter issuing a one-clk tick at mid-bit.
module uart_rx_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 1250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV / 2);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= (!en || cnt == LAST) ? '0 : cnt + CNT_W'(1);
    assign tick = en && cnt == HALF;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver; samples each bit at its middle and reports framed bytes
// or stop-bit errors as single-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 1250
) (
    input logic clk,
    input logic rst_n,
    uart_rx_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    state_t state, next;
    logic [2:0] sync;
    logic rx_s, fall, tick, load, ferr, shift, valid, err;
    logic [IDX_W-1:0] idx;
    logic [DATA_BITS-1:0] sh, data;
    // sync[1] is the synchronized line; sync[2] is its delayed copy for edge detect
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= 3'b111;
        else sync <= {sync[1:0], bus.rx};
    assign rx_s = sync[1];
    assign fall = sync[2] & ~sync[1];
    uart_rx_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(clk),
        .rst_n(rst_n),
        .en(state != IDLE),
        .tick(tick)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        load = 1'b0;
        ferr = 1'b0;
        shift = 1'b0;
        case (state)
            IDLE: next = fall ? START : IDLE;
            START: next = tick ? (rx_s ? IDLE : DATA) : START;
            DATA: begin
                shift = tick;
                next = (tick && idx == LAST_IDX) ? STOP : DATA;
            end
            STOP: begin
                next = tick ? IDLE : STOP;
                load = tick && rx_s;
                ferr = tick && !rx_s;
            end
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx <= '0;
            sh <= '0;
            data <= '0;
            valid <= 1'b0;
            err <= 1'b0;
        end else begin
            valid <= load;
            err <= ferr;
            if (state == START) idx <= '0;
            else if (shift) idx <= idx + IDX_W'(1);
            if (shift) sh[idx] <= rx_s;
            if (load) data <= sh;
        end
    assign bus.rx_data = data;
    assign bus.rx_valid = valid;
    assign bus.frame_err = err;
    assign bus.rx_busy = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames on a fast (16) and a real-rate (1250)
// receiver, checked against a last-good-byte / pulse-count model.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int DIV_F = 16;
    localparam int DIV_S = 1250;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    uart_rx_if bf();
    uart_rx_if bs();
    uart_rx #(.CLK_DIV(DIV_F)) dut_f (.clk(clk), .rst_n(rst_n), .bus(bf.slave));
    uart_rx #(.CLK_DIV(DIV_S)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs.slave));
    int checks = 0, fails = 0;
    int cyc = 0, fall_cyc = 0, lat = 0;
    int vf = 0, ef = 0, vs = 0, es = 0, both = 0;
    logic [7:0] got_f[$];
    logic [7:0] exp_f = 8'h00;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bf.rx_valid) begin
            vf <= vf + 1;
            got_f.push_back(bf.rx_data);
            lat <= cyc - fall_cyc;
        end
        if (bf.frame_err) ef <= ef + 1;
        if (bs.rx_valid) vs <= vs + 1;
        if (bs.frame_err) es <= es + 1;
        if ((bf.rx_valid && bf.frame_err) || (bs.rx_valid && bs.frame_err)) both <= both + 1;
    end
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // Drives one whole frame; caller is just past a posedge.
    task automatic send(input bit slow, input logic [7:0] d, input bit stop, input int per);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (slow) bs.rx = f[i];
            else bf.rx = f[i];
            if (i == 0) fall_cyc = cyc;
            repeat (per) @(posedge clk);
            #1;
        end
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        idle(3);
        checks++; if (bf.rx_data !== 8'h00) begin fails++; $display("FAIL reset_data_f: got %h want 00", bf.rx_data); end
        checks++; if ({bf.rx_valid, bf.frame_err, bf.rx_busy} !== 3'b000) begin fails++; $display("FAIL reset_flags_f: got %b want 000", {bf.rx_valid, bf.frame_err, bf.rx_busy}); end
        checks++; if ({bs.rx_data, bs.rx_valid, bs.frame_err, bs.rx_busy} !== 11'h0) begin fails++; $display("FAIL reset_s: got %h want 000", {bs.rx_data, bs.rx_valid, bs.frame_err, bs.rx_busy}); end
        rst_n = 1'b1;
        idle(4);
    endtask
    task automatic test_basic;
        int v0, e0;
        v0 = vf; e0 = ef;
        send(0, 8'hA5, 1'b1, DIV_F);
        exp_f = 8'hA5;
        idle(4);
        checks++; if (bf.rx_data !== exp_f) begin fails++; $display("FAIL basic_data: got %h want %h", bf.rx_data, exp_f); end
        checks++; if (vf - v0 != 1) begin fails++; $display("FAIL basic_valid: got %0d pulses want 1", vf - v0); end
        checks++; if (ef - e0 != 0) begin fails++; $display("FAIL basic_ferr: got %0d pulses want 0", ef - e0); end
        checks++; if (bf.rx_busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b want 0", bf.rx_busy); end
        checks++; if (lat < 9 * DIV_F + DIV_F / 2 || lat > 9 * DIV_F + DIV_F / 2 + 6) begin fails++; $display("FAIL basic_latency: got %0d want %0d..%0d", lat, 9 * DIV_F + DIV_F / 2, 9 * DIV_F + DIV_F / 2 + 6); end
    endtask
    task automatic test_random;
        int v0, e0, nv, ne;
        logic [7:0] d;
        bit stop;
        for (int k = 0; k < 10; k++) begin
            v0 = vf; e0 = ef;
            d = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            send(0, d, stop, DIV_F);
            bf.rx = 1'b1;
            idle(2 + $urandom_range(0, 20));
            nv = stop ? 1 : 0;
            ne = stop ? 0 : 1;
            if (stop) exp_f = d;
            checks++; if (bf.rx_data !== exp_f) begin fails++; $display("FAIL random_data[%0d]: got %h want %h", k, bf.rx_data, exp_f); end
            checks++; if (vf - v0 != nv) begin fails++; $display("FAIL random_valid[%0d]: got %0d want %0d", k, vf - v0, nv); end
            checks++; if (ef - e0 != ne) begin fails++; $display("FAIL random_ferr[%0d]: got %0d want %0d", k, ef - e0, ne); end
        end
    endtask
    task automatic test_false_start;
        int v0, e0;
        v0 = vf; e0 = ef;
        bf.rx = 1'b0;
        idle(4);
        checks++; if (bf.rx_busy !== 1'b1) begin fails++; $display("FAIL false_start_busy_hi: got %b want 1", bf.rx_busy); end
        bf.rx = 1'b1;
        idle(3 * DIV_F);
        checks++; if (bf.rx_busy !== 1'b0) begin fails++; $display("FAIL false_start_idle: got %b want 0", bf.rx_busy); end
        checks++; if (vf - v0 != 0 || ef - e0 != 0) begin fails++; $display("FAIL false_start_pulses: got v=%0d e=%0d want 0 0", vf - v0, ef - e0); end
        checks++; if (bf.rx_data !== exp_f) begin fails++; $display("FAIL false_start_data: got %h want %h", bf.rx_data, exp_f); end
    endtask
    task automatic test_frame_err;
        int v0, e0;
        v0 = vf; e0 = ef;
        send(0, 8'h5A, 1'b1, DIV_F);
        idle(5);
        send(0, 8'h3C, 1'b0, DIV_F);
        bf.rx = 1'b1;
        idle(5);
        exp_f = 8'h5A;
        checks++; if (vf - v0 != 1) begin fails++; $display("FAIL ferr_valid: got %0d want 1", vf - v0); end
        checks++; if (ef - e0 != 1) begin fails++; $display("FAIL ferr_count: got %0d want 1", ef - e0); end
        checks++; if (bf.rx_data !== exp_f) begin fails++; $display("FAIL ferr_data: got %h want %h", bf.rx_data, exp_f); end
    endtask
    task automatic test_back_to_back;
        int v0, q0;
        v0 = vf; q0 = got_f.size();
        send(0, 8'h00, 1'b1, DIV_F);
        send(0, 8'hFF, 1'b1, DIV_F);
        idle(5);
        exp_f = 8'hFF;
        checks++; if (vf - v0 != 2) begin fails++; $display("FAIL b2b_valid: got %0d want 2", vf - v0); end
        checks++; if (got_f.size() < q0 + 2 || got_f[q0] !== 8'h00) begin fails++; $display("FAIL b2b_first: got %h want 00", got_f.size() > q0 ? got_f[q0] : 8'hxx); end
        checks++; if (got_f.size() < q0 + 2 || got_f[q0 + 1] !== 8'hFF) begin fails++; $display("FAIL b2b_second: got %h want ff", got_f.size() > q0 + 1 ? got_f[q0 + 1] : 8'hxx); end
        checks++; if (bf.rx_data !== exp_f) begin fails++; $display("FAIL b2b_data: got %h want %h", bf.rx_data, exp_f); end
    endtask
    task automatic test_reset_abort;
        int v0, e0;
        logic [9:0] f;
        v0 = vf; e0 = ef;
        f = {1'b1, 8'($urandom), 1'b0};
        for (int i = 0; i < 6; i++) begin
            bf.rx = f[i];
            idle(i == 5 ? DIV_F / 2 : DIV_F);
        end
        rst_n = 1'b0;
        bf.rx = 1'b1;
        exp_f = 8'h00;
        idle(5);
        checks++; if (bf.rx_data !== exp_f || bf.rx_busy !== 1'b0) begin fails++; $display("FAIL abort_in_reset: got data=%h busy=%b want %h 0", bf.rx_data, bf.rx_busy, exp_f); end
        rst_n = 1'b1;
        idle(2 * DIV_F);
        checks++; if (vf - v0 != 0 || ef - e0 != 0) begin fails++; $display("FAIL abort_pulses: got v=%0d e=%0d want 0 0", vf - v0, ef - e0); end
        send(0, 8'h81, 1'b1, DIV_F);
        idle(5);
        exp_f = 8'h81;
        checks++; if (bf.rx_data !== exp_f) begin fails++; $display("FAIL abort_next_data: got %h want %h", bf.rx_data, exp_f); end
        checks++; if (vf - v0 != 1 || ef - e0 != 0) begin fails++; $display("FAIL abort_next_pulses: got v=%0d e=%0d want 1 0", vf - v0, ef - e0); end
    endtask
    task automatic test_skew;
        int v0, e0, per;
        for (int k = 0; k < 2; k++) begin
            per = k == 0 ? DIV_S * 98 / 100 : DIV_S * 102 / 100;
            v0 = vs; e0 = es;
            send(1, 8'h55, 1'b1, per);
            idle(20);
            checks++; if (bs.rx_data !== 8'h55) begin fails++; $display("FAIL skew_data[%0d]: got %h want 55", per, bs.rx_data); end
            checks++; if (vs - v0 != 1 || es - e0 != 0) begin fails++; $display("FAIL skew_pulses[%0d]: got v=%0d e=%0d want 1 0", per, vs - v0, es - e0); end
        end
    endtask
    initial begin
        bf.rx = 1'b1;
        bs.rx = 1'b1;
        test_reset;
        test_basic;
        test_random;
        test_false_start;
        test_frame_err;
        test_back_to_back;
        test_reset_abort;
        test_skew;
        checks++; if (both != 0) begin fails++; $display("FAIL valid_and_ferr_overlap: got %0d cycles want 0", both); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
